// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between a data-memory initiator and responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - 1 KiB byte-addressed data memory with fixed wait states and one outstanding request
module dmem_responder #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  bytes [0:1023];

  logic [3:0]  cnt;
  logic        cap_write;
  logic [9:0]  cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        access;
  logic        misaligned;
  logic [31:0] load_word;
  logic        unused_addr_bits;

  assign accept     = (state == IDLE) && bus.req_valid;
  assign access     = (state == BUSY) && (cnt == 4'd0);
  assign misaligned = (cap_addr[1:0] != 2'b00);
  // 10-bit index sums wrap naturally at the end of the array
  assign load_word  = {bytes[cap_addr + 10'd3], bytes[cap_addr + 10'd2],
                       bytes[cap_addr + 10'd1], bytes[cap_addr]};
  assign unused_addr_bits = ^bus.req_addr[31:10];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid)      state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0)        state_nxt = RESP;
      RESP:    if (bus.resp_ready)     state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      cnt       <= WAIT_INIT;
      cap_write <= bus.req_write;
      cap_addr  <= bus.req_addr[9:0];
      cap_wdata <= bus.req_wdata;
      cap_be    <= bus.req_be;
    end else if (state == BUSY) begin
      if (cnt == 4'd0) begin
        rdata_q <= (!cap_write && !misaligned) ? load_word : 32'd0;
        err_q   <= misaligned;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Storage has no reset so preloaded contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (!reset && access && cap_write && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_be[i]) begin
          bytes[cap_addr + 10'(i)] <= cap_wdata[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at WAIT_CYCLES 2 and 0
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mdl [2][1024];
  logic [32:0] exp_q [$];

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.WAIT_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(bus_a.slave));
  dmem_responder #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus_b.slave));

  always #5 clk = ~clk;

  assign bus_a.req_valid  = req_valid & ~sel;
  assign bus_a.req_write  = req_write;
  assign bus_a.req_addr   = req_addr;
  assign bus_a.req_wdata  = req_wdata;
  assign bus_a.req_be     = req_be;
  assign bus_a.resp_ready = resp_ready & ~sel;
  assign bus_b.req_valid  = req_valid & sel;
  assign bus_b.req_write  = req_write;
  assign bus_b.req_addr   = req_addr;
  assign bus_b.req_wdata  = req_wdata;
  assign bus_b.req_be     = req_be;
  assign bus_b.resp_ready = resp_ready & sel;

  logic        m_req_ready, m_resp_valid, m_resp_err;
  logic [31:0] m_resp_rdata;
  assign m_req_ready  = sel ? bus_b.req_ready  : bus_a.req_ready;
  assign m_resp_valid = sel ? bus_b.resp_valid : bus_a.resp_valid;
  assign m_resp_err   = sel ? bus_b.resp_err   : bus_a.resp_err;
  assign m_resp_rdata = sel ? bus_b.resp_rdata : bus_a.resp_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("sb_rdata", m_resp_rdata, e[31:0]);
        check("sb_err", {31'd0, m_resp_err}, {31'd0, e[32]});
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_req_ready && n < 20);
    check("req_ready_before_accept", {31'd0, m_req_ready}, 32'd1);
  endtask

  task automatic do_req(input bit s, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int bp, input bit hold);
    logic [9:0]  a;
    logic [31:0] er;
    logic [31:0] r0;
    logic        e0;
    bit          ee;
    int          n;
    int          w;
    w = s ? 0 : 2;
    sel = s;
    req_write = wr;
    req_addr = addr;
    req_wdata = wd;
    req_be = be;
    req_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    a  = addr[9:0];
    ee = (a[1:0] != 2'b00);
    er = 32'd0;
    if (!ee && wr) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mdl[s][a + 10'(i)] = wd[8*i +: 8];
    end else if (!ee) begin
      er = {mdl[s][a + 10'd3], mdl[s][a + 10'd2], mdl[s][a + 10'd1], mdl[s][a]};
    end
    exp_q.push_back({ee, er});
    if (!hold) req_valid = 1'b0;
    req_addr = $urandom;
    req_wdata = $urandom;
    req_be = 4'($urandom);
    req_write = ~wr;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_resp_valid && n < 40);
    check("latency", 32'(n), 32'(w + 1));
    r0 = m_resp_rdata;
    e0 = m_resp_err;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", {31'd0, m_resp_valid}, 32'd1);
      check("stall_rdata", m_resp_rdata, r0);
      check("stall_err", {31'd0, m_resp_err}, {31'd0, e0});
      check("stall_req_ready", {31'd0, m_req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    req_valid = 1'b0;
    check("post_hs_valid", {31'd0, m_resp_valid}, 32'd0);
    check("post_hs_req_ready", {31'd0, m_req_ready}, 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_req_ready", {31'd0, bus_a.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
    check("rst_rdata", bus_a.resp_rdata, 32'd0);
    check("rst_err", {31'd0, bus_a.resp_err}, 32'd0);
    check("rst0_req_ready", {31'd0, bus_b.req_ready}, 32'd1);
    check("rst0_resp_valid", {31'd0, bus_b.resp_valid}, 32'd0);

    do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    do_req(0, 0, 32'h10, 32'h0, 4'h0, 0, 0);

    do_req(0, 1, 32'h20, 32'h11223344, 4'hF, 0, 0);
    do_req(0, 1, 32'h24, 32'h55667788, 4'hF, 0, 0);
    do_req(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0);
    do_req(0, 0, 32'h20, 32'h0, 4'hF, 1, 0);

    do_req(0, 0, 32'h22, 32'h0, 4'h0, 0, 0);
    do_req(0, 1, 32'h21, 32'h99999999, 4'hF, 0, 0);
    do_req(0, 0, 32'h20, 32'h0, 4'h0, 0, 0);
    do_req(0, 0, 32'h24, 32'h0, 4'h0, 0, 0);

    do_req(0, 1, 32'h10, 32'h12345678, 4'h0, 0, 0);
    do_req(0, 0, 32'h10, 32'h0, 4'h0, 5, 1);

    do_req(0, 1, 32'h30, 32'h01020304, 4'hF, 0, 0);
    sel = 1'b0;
    req_write = 1'b1;
    req_addr = 32'h30;
    req_wdata = 32'hFFFFFFFF;
    req_be = 4'hF;
    req_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_req_ready", {31'd0, m_req_ready}, 32'd1);
    check("midrst_rdata", m_resp_rdata, 32'd0);
    check("midrst_err", {31'd0, m_resp_err}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("midrst_no_resp", {31'd0, m_resp_valid}, 32'd0);
    end
    do_req(0, 0, 32'h30, 32'h0, 4'h0, 0, 0);

    do_req(1, 1, 32'h000, 32'hCAFEF00D, 4'hF, 0, 0);
    do_req(1, 0, 32'h400, 32'h0, 4'h0, 0, 0);
    do_req(1, 1, 32'h3FC, 32'h0BADC0DE, 4'hF, 0, 0);
    do_req(1, 0, 32'h7FC, 32'h0, 4'h0, 2, 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WAIT_CYCLES SHALL default to 2 and set the wait states before each access; legal range is 0..15.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock, with all state changing on posedge.
REQ-004 Port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 Port req_valid SHALL be an input, 1 bit wide: the initiator presents a request.
REQ-006 Port req_ready SHALL be an output, 1 bit wide: the responder can accept a request.
REQ-007 Port req_write SHALL be an input, 1 bit wide: 1 means store, 0 means load.
REQ-008 Port req_addr SHALL be an input, 32 bits wide: a byte address of which only [9:0] is used.
REQ-009 Port req_wdata SHALL be an input, 32 bits wide: store data, little-endian.
REQ-010 Port req_be SHALL be an input, 4 bits wide: store byte enables, where be[i] selects byte addr+i.
REQ-011 Port resp_valid SHALL be an output, 1 bit wide: a response is present.
REQ-012 Port resp_ready SHALL be an input, 1 bit wide: the initiator accepts the response.
REQ-013 Port resp_rdata SHALL be an output, 32 bits wide: load data, little-endian.
REQ-014 Port resp_err SHALL be an output, 1 bit wide: the request was misaligned.

Function
REQ-015 Storage SHALL be a byte array named bytes, indexed 0..1023 and 8 bits per entry, so that $readmemh preload works.
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-017 In IDLE, req_ready SHALL be 1; in BUSY and RESP it SHALL be 0.
REQ-018 A request SHALL be accepted on a posedge where req_valid and req_ready are both 1.
REQ-019 On acceptance, the block SHALL capture write, addr[9:0], wdata and be, load a 4-bit counter with WAIT_CYCLES, and enter BUSY.
REQ-020 On each BUSY posedge: if the counter is 0, the block SHALL perform the access and enter RESP; otherwise it SHALL decrement the counter.
REQ-021 Latency SHALL be as follows: resp_valid is first 1 after posedge number WAIT_CYCLES+1 counted from the accept edge (the accept edge is edge 0).
REQ-022 For a store, the write SHALL update only the enabled bytes, at the access edge.
REQ-023 A store with be=0000 SHALL leave memory unchanged and still produce a normal response.
REQ-024 For a load, resp_rdata SHALL be {bytes[a+3], bytes[a+2], bytes[a+1], bytes[a]} sampled at the access edge, and be SHALL be ignored.
REQ-025 For a store, resp_rdata SHALL be 0.
REQ-026 Byte index arithmetic SHALL be 10 bits wide and wrap modulo 1024; for example, addr 0x400 aliases addr 0x000.
REQ-027 A request with captured addr[1:0] not equal to 00 SHALL set resp_err=1 and resp_rdata=0, perform no write, and keep the same latency.
REQ-028 In RESP, resp_valid SHALL be 1, and resp_rdata and resp_err SHALL hold stable until a posedge with resp_ready=1; that posedge SHALL return the FSM to IDLE.
REQ-029 resp_ready SHALL have no effect outside RESP.
REQ-030 At most one request SHALL be outstanding; req_valid in BUSY or RESP SHALL be ignored, and the initiator must hold it.
REQ-031 req_ready SHALL not depend combinationally on resp_ready: a new request is accepted no earlier than the first IDLE cycle after the response handshake.
REQ-032 Request inputs SHALL be sampled only on the accept edge; later changes SHALL not affect the pending access.

Reset
REQ-033 Reset SHALL force IDLE, counter=0, resp_valid=0, resp_err=0, resp_rdata=0 and req_ready=1 after the reset edge.
REQ-034 Reset SHALL take priority over every other event on the same edge, including acceptance, the access edge and the response handshake.
REQ-035 Reset in BUSY SHALL drop the pending request: no write and no response.
REQ-036 Reset SHALL not alter the contents of bytes.

Verification
REQ-037 Aligned store/load with WAIT=2: store 0xDEADBEEF to 0x10 with be=1111, then load 0x10 -> resp_valid rises after the third edge from accept and resp_rdata=0xDEADBEEF.
REQ-038 Byte enables: preload 0x11223344 at 0x20, store 0xAABBCCDD with be=0101, then load 0x20 -> resp_rdata=0x11BB33DD.
REQ-039 Misaligned access: load 0x22 -> resp_err=1 and resp_rdata=0; store to 0x21 -> bytes 0x20..0x27 unchanged.
REQ-040 Backpressure: hold resp_ready=0 for 5 cycles while req_valid=1 -> resp_valid, resp_rdata and resp_err stay stable, req_ready stays 0, and no second acceptance occurs.
REQ-041 Reset mid-operation: reset in BUSY after a store of 0xFFFFFFFF to 0x30 -> no response, and 0x30 retains its preload.
REQ-042 WAIT_CYCLES=0 with wrap: load 0x400 -> response after edge 1 from accept, with data equal to bytes 0..3.
